// File: rtl/decode_regfile_pkg.sv
// decode_regfile_pkg: shared CPU encodings for destination and write-data selection
package decode_regfile_pkg;

    typedef enum logic [1:0] {
        DST_B    = 2'b00,
        DST_C    = 2'b01,
        DST_LINK = 2'b10,
        DST_A    = 2'b11
    } reg_dst_e;

    typedef enum logic [1:0] {
        WD_ALU = 2'b00,
        WD_MEM = 2'b01,
        WD_PC  = 2'b10,
        WD_IMM = 2'b11
    } wd_sel_e;

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register array with one write port and two registered, write-through read ports
module regfile_2r1w #(
    parameter int DATA_W   = 16,
    parameter int NREGS    = 16,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(NREGS)-1:0] raddr1,
    input  logic [$clog2(NREGS)-1:0] raddr2,
    output logic [DATA_W-1:0]        rdata1,
    output logic [DATA_W-1:0]        rdata2
);

    logic [DATA_W-1:0] regs [NREGS];
    logic              wen;

    // register 0 is never written when hardwired, so it stays at its reset value of zero
    assign wen = we && !(ZERO_REG != 0 && waddr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            if (wen) regs[waddr] <= wdata;
            rdata1 <= (wen && waddr == raddr1) ? wdata : regs[raddr1];
            rdata2 <= (wen && waddr == raddr2) ? wdata : regs[raddr2];
        end
    end

endmodule

// File: rtl/decode_regfile.sv
// decode_regfile: instruction register with field decode feeding a 2-read/1-write register file
module decode_regfile import decode_regfile_pkg::*; #(
    parameter int DATA_W   = 16,
    parameter int NREGS    = 16,
    parameter int ZERO_REG = 0,
    parameter int LINK_REG = NREGS - 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                IRWrite,
    input  logic [DATA_W-1:0]   MemData,
    input  logic                RegWrite,
    input  logic [1:0]          RegDst,
    input  logic [1:0]          MemToReg,
    input  logic [DATA_W-1:0]   ALURegOut,
    input  logic [DATA_W-1:0]   MemDataReg,
    input  logic [DATA_W-1:0]   PC,
    output logic [DATA_W/4-1:0] ir_op,
    output logic [DATA_W/4-1:0] ir_a,
    output logic [DATA_W/4-1:0] ir_b,
    output logic [DATA_W/4-1:0] ir_c,
    output logic [DATA_W-1:0]   read1,
    output logic [DATA_W-1:0]   read2
);

    localparam int AW = $clog2(NREGS);
    localparam int H  = DATA_W / 2;

    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] wdata;
    logic [AW-1:0]     waddr;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) ir <= '0;
        else if (IRWrite) ir <= MemData;
    end

    assign {ir_op, ir_a, ir_b, ir_c} = ir;

    // addressing always uses the IR as it stands this cycle, so a simultaneous load only affects later cycles
    always_comb begin
        waddr = RegDst == DST_B    ? ir_b[AW-1:0] :
                RegDst == DST_C    ? ir_c[AW-1:0] :
                RegDst == DST_LINK ? AW'(LINK_REG) : ir_a[AW-1:0];
        wdata = MemToReg == WD_ALU ? ALURegOut :
                MemToReg == WD_MEM ? MemDataReg :
                MemToReg == WD_PC  ? PC : {{H{ir[H-1]}}, ir[H-1:0]};
    end

    regfile_2r1w #(
        .DATA_W  (DATA_W),
        .NREGS   (NREGS),
        .ZERO_REG(ZERO_REG)
    ) u_rf (
        .clk   (Clock),
        .rst   (Reset),
        .we    (RegWrite),
        .waddr (waddr),
        .wdata (wdata),
        .raddr1(ir_a[AW-1:0]),
        .raddr2(ir_b[AW-1:0]),
        .rdata1(read1),
        .rdata2(read2)
    );

endmodule

// File: tb/tb_decode_regfile.sv
// tb_decode_regfile: vector table, directed corner cases and random traffic against a reference model
module tb_decode_regfile;

    logic        Clock = 1'b0;
    logic        Reset, IRWrite, RegWrite;
    logic [15:0] MemData, ALURegOut, MemDataReg, PC;
    logic [1:0]  RegDst, MemToReg;
    logic [3:0]  ir_op, ir_a, ir_b, ir_c, zir_op, zir_a, zir_b, zir_c;
    logic [15:0] read1, read2, zread1, zread2;

    int tests = 0;
    int failed = 0;

    decode_regfile #(.DATA_W(16), .NREGS(16), .ZERO_REG(0)) dut (
        .Clock(Clock), .Reset(Reset), .IRWrite(IRWrite), .MemData(MemData),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
        .ALURegOut(ALURegOut), .MemDataReg(MemDataReg), .PC(PC),
        .ir_op(ir_op), .ir_a(ir_a), .ir_b(ir_b), .ir_c(ir_c),
        .read1(read1), .read2(read2)
    );

    decode_regfile #(.DATA_W(16), .NREGS(16), .ZERO_REG(1)) dut_z (
        .Clock(Clock), .Reset(Reset), .IRWrite(IRWrite), .MemData(MemData),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
        .ALURegOut(ALURegOut), .MemDataReg(MemDataReg), .PC(PC),
        .ir_op(zir_op), .ir_a(zir_a), .ir_b(zir_b), .ir_c(zir_c),
        .read1(zread1), .read2(zread2)
    );

    always #5 Clock = ~Clock;

    // reference state: index 0 is the plain file, index 1 the file with a hardwired zero register
    logic [15:0] m_rf [2][16];
    logic [15:0] m_ir;
    logic [15:0] m_r1 [2];
    logic [15:0] m_r2 [2];

    typedef struct {
        logic        irw;
        logic [15:0] mem;
        logic        rw;
        logic [1:0]  dst;
        logic [15:0] alu;
        logic        chk;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t vec [12];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            for (int r = 0; r < 16; r++) m_rf[z][r] = 16'h0;
            m_r1[z] = 16'h0;
            m_r2[z] = 16'h0;
        end
        m_ir = 16'h0;
    endtask

    task automatic model_step();
        int a, b, c, wa;
        logic [15:0] wd;
        a = int'(m_ir[11:8]);
        b = int'(m_ir[7:4]);
        c = int'(m_ir[3:0]);
        wa = (RegDst == 2'd0) ? b : (RegDst == 2'd1) ? c : (RegDst == 2'd2) ? 15 : a;
        if (MemToReg == 2'd0) wd = ALURegOut;
        else if (MemToReg == 2'd1) wd = MemDataReg;
        else if (MemToReg == 2'd2) wd = PC;
        else wd = (m_ir[7:0] >= 8'd128) ? 16'hFF00 + 16'(m_ir[7:0]) : 16'(m_ir[7:0]);
        for (int z = 0; z < 2; z++) begin
            if (RegWrite && !(z == 1 && wa == 0)) m_rf[z][wa] = wd;
            m_r1[z] = m_rf[z][a];
            m_r2[z] = m_rf[z][b];
        end
        if (IRWrite) m_ir = MemData;
    endtask

    task automatic drive(input logic irw, input logic [15:0] mem, input logic rw,
                         input logic [1:0] dst, input logic [1:0] m2r, input logic [15:0] alu);
        IRWrite = irw;
        MemData = mem;
        RegWrite = rw;
        RegDst = dst;
        MemToReg = m2r;
        ALURegOut = alu;
    endtask

    task automatic cycle();
        @(posedge Clock);
        model_step();
        @(negedge Clock);
        chk("model ir", {ir_op, ir_a, ir_b, ir_c}, m_ir);
        chk("model ir z", {zir_op, zir_a, zir_b, zir_c}, m_ir);
        chk("model read1", read1, m_r1[0]);
        chk("model read2", read2, m_r2[0]);
        chk("model read1 z", zread1, m_r1[1]);
        chk("model read2 z", zread2, m_r2[1]);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " ir"}, {ir_op, ir_a, ir_b, ir_c}, 16'h0);
        chk({name, " read1"}, read1, 16'h0);
        chk({name, " read2"}, read2, 16'h0);
        chk({name, " read1 z"}, zread1, 16'h0);
        chk({name, " read2 z"}, zread2, 16'h0);
    endtask

    initial begin
        logic [15:0] wvals [7];
        wvals = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1337, 16'h0231, 16'hDEAD, 16'hBEEF};
        // each write row preloads field A for the next row while writing through the current IR
        for (int i = 0; i < 7; i++)
            vec[i] = '{1'b1, 16'((i + 1) << 8), 1'b1, 2'b11, wvals[i], 1'b0, 16'h0, 16'h0};
        vec[7]  = '{1'b1, 16'h0010, 1'b0, 2'b11, 16'h0, 1'b0, 16'h0, 16'h0};
        vec[8]  = '{1'b1, 16'h0230, 1'b0, 2'b11, 16'h0, 1'b1, 16'h1234, 16'h0000};
        vec[9]  = '{1'b1, 16'h0450, 1'b0, 2'b11, 16'h0, 1'b1, 16'hFFFF, 16'h1337};
        vec[10] = '{1'b1, 16'h0670, 1'b0, 2'b11, 16'h0, 1'b1, 16'h0231, 16'hDEAD};
        vec[11] = '{1'b0, 16'h0000, 1'b0, 2'b11, 16'h0, 1'b1, 16'hBEEF, 16'h0000};

        Reset = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 2'b00, 2'b00, 16'h0);
        MemDataReg = 16'h0;
        PC = 16'h0;
        model_reset();
        repeat (2) @(negedge Clock);
        chk_all_zero("reset");
        Reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vec[i].irw, vec[i].mem, vec[i].rw, vec[i].dst, 2'b00, vec[i].alu);
            cycle();
            if (vec[i].chk) begin
                chk($sformatf("tbl%0d read1", i), read1, vec[i].e1);
                chk($sformatf("tbl%0d read2", i), read2, vec[i].e2);
            end
        end

        drive(1'b1, 16'h1234, 1'b0, 2'b00, 2'b00, 16'h0);
        cycle();
        chk("load op", 16'(ir_op), 16'h1);
        chk("load a", 16'(ir_a), 16'h2);
        chk("load b", 16'(ir_b), 16'h3);
        chk("load c", 16'(ir_c), 16'h4);
        drive(1'b0, 16'hFFFF, 1'b0, 2'b00, 2'b00, 16'h0);
        cycle();
        chk("hold ir", {ir_op, ir_a, ir_b, ir_c}, 16'h1234);

        drive(1'b1, 16'h0550, 1'b0, 2'b00, 2'b00, 16'h0);
        cycle();
        drive(1'b0, 16'h0, 1'b1, 2'b11, 2'b00, 16'hCAFE);
        cycle();
        chk("bypass read1", read1, 16'hCAFE);
        chk("bypass read2", read2, 16'hCAFE);

        drive(1'b1, 16'h0880, 1'b0, 2'b00, 2'b00, 16'h0);
        cycle();
        drive(1'b1, 16'h0F00, 1'b1, 2'b11, 2'b11, 16'h0);
        cycle();
        chk("imm sext", read1, 16'hFF80);
        PC = 16'h0042;
        drive(1'b0, 16'h0, 1'b1, 2'b10, 2'b10, 16'h0);
        cycle();
        chk("link pc bypass", read1, 16'h0042);
        drive(1'b0, 16'h0, 1'b0, 2'b00, 2'b00, 16'h0);
        cycle();
        chk("link pc", read1, 16'h0042);

        drive(1'b1, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0);
        cycle();
        drive(1'b0, 16'h0, 1'b1, 2'b11, 2'b00, 16'hAAAA);
        cycle();
        chk("r0 bypass z", zread1, 16'h0000);
        chk("r0 bypass", read1, 16'hAAAA);
        drive(1'b0, 16'h0, 1'b0, 2'b00, 2'b00, 16'h0);
        cycle();
        chk("r0 read z", zread2, 16'h0000);
        chk("r0 read", read2, 16'hAAAA);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 2) == 0), 16'($urandom), 1'($urandom),
                  2'($urandom), 2'($urandom), 16'($urandom));
            MemDataReg = 16'($urandom);
            PC = 16'($urandom);
            cycle();
        end

        drive(1'b1, 16'h0300, 1'b0, 2'b00, 2'b00, 16'h0);
        cycle();
        drive(1'b0, 16'h0, 1'b1, 2'b11, 2'b00, 16'h5555);
        #2 Reset = 1'b1;
        #1 chk_all_zero("async reset");
        @(posedge Clock);
        @(negedge Clock);
        chk_all_zero("reset held");
        Reset = 1'b0;
        model_reset();
        drive(1'b1, 16'h0300, 1'b1, 2'b11, 2'b00, 16'h7777);
        cycle();
        drive(1'b0, 16'h0, 1'b0, 2'b00, 2'b00, 16'h0);
        cycle();
        chk("reset write dropped", read1, 16'h0000);
        chk("first write after reset", read2, 16'h7777);
        chk("first write after reset z", zread2, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
